// File: rtl/rdata_fwft_pkg.sv
// Shared constants for the read-side first-word-fall-through adapter.
package rdata_fwft_pkg;

  // Default data word width.
  localparam int unsigned DsizeDefault = 8;

  // Width of the buffered-word count (holds 0..2).
  localparam int unsigned CountWidth = 2;

endpackage

// File: rtl/rdata_fwft_if.sv
// FIFO read-port and consumer handshake bundle for rdata_fwft.
interface rdata_fwft_if
  import rdata_fwft_pkg::*;
#(
  parameter int unsigned DSIZE = DsizeDefault
);

  logic                  rempty;
  logic [DSIZE-1:0]      rdata;
  logic                  rinc;
  logic                  dout_valid;
  logic                  dout_ready;
  logic [DSIZE-1:0]      dout_data;
  logic [CountWidth-1:0] dout_count;

  // Adapter side.
  modport slave (
    input  rempty, rdata, dout_ready,
    output rinc, dout_valid, dout_data, dout_count
  );

  // Environment side: FIFO memory/pointer logic plus the consumer.
  modport master (
    output rempty, rdata, dout_ready,
    input  rinc, dout_valid, dout_data, dout_count
  );

endinterface

// File: rtl/fwft_buf2.sv
// Two-entry register buffer: one write port, one asynchronous read port.
module fwft_buf2
  import rdata_fwft_pkg::*;
#(
  parameter int unsigned DSIZE = DsizeDefault
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             widx_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic             ridx_i,
  output logic [DSIZE-1:0] rdata_o
);

  logic [DSIZE-1:0] mem_q [2];
  logic [DSIZE-1:0] mem_d [2];

  // Next contents: write the addressed entry, hold the other.
  always_comb begin
    mem_d = mem_q;
    if (we_i) mem_d[widx_i] = wdata_i;
  end

  // Data storage; contents are don't-care after reset so no reset term.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/rdata_fwft.sv
// First-word-fall-through adapter on a FIFO read port: prefetches up to two words
// so the head word is presented on dout_data without a consumer request.
module rdata_fwft
  import rdata_fwft_pkg::*;
#(
  parameter int unsigned DSIZE    = DsizeDefault,
  parameter int unsigned ADDRSIZE = 4
) (
  input logic         rclk,
  input logic         rrst,
  rdata_fwft_if.slave bus
);

  localparam int unsigned LvlW = CountWidth + 1;

  if (DSIZE == 0 || ADDRSIZE == 0) begin : gen_param_check
    $error("rdata_fwft: DSIZE and ADDRSIZE must be non-zero");
  end

  logic [CountWidth-1:0] count_q, count_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic                  inflight_q, inflight_d;
  logic                  pop;
  logic                  wr;
  logic [LvlW-1:0]       level;
  logic [DSIZE-1:0]      head_word;

  // Outputs and read credit; everything is forced idle in the reset cycle.
  always_comb begin
    bus.dout_valid = !rrst && (count_q != '0);
    bus.dout_count = rrst ? '0 : count_q;
    bus.dout_data  = head_word;
    pop            = bus.dout_valid && bus.dout_ready;
    wr             = inflight_q && !rrst;
    // Words held or on their way, after this cycle's pop; pop implies count >= 1.
    level          = LvlW'(count_q) + LvlW'(inflight_q) - LvlW'(pop);
    bus.rinc       = !rrst && !bus.rempty && (level < LvlW'(2));
  end

  // Next-state for pointers, count and the in-flight read marker.
  always_comb begin
    inflight_d = bus.rinc;
    head_d     = head_q ^ pop;
    tail_d     = tail_q ^ wr;
    count_d    = count_q + CountWidth'(wr) - CountWidth'(pop);
  end

  // Control state with synchronous reset; an in-flight word is dropped on reset.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      count_q    <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
    end
  end

  fwft_buf2 #(
    .DSIZE (DSIZE)
  ) u_buf (
    .clk_i   (rclk),
    .we_i    (wr),
    .widx_i  (tail_q),
    .wdata_i (bus.rdata),
    .ridx_i  (head_q),
    .rdata_o (head_word)
  );

endmodule

// File: tb/tb_rdata_fwft.sv
// Self-checking bench for rdata_fwft: a queue-based reference of the FIFO and
// the adapter's word buffer, driven by directed steps then random traffic.
module tb_rdata_fwft;
  import rdata_fwft_pkg::*;

  localparam int unsigned DW = 8;

  logic rclk = 1'b0;
  logic rrst;

  always #5 rclk = ~rclk;

  rdata_fwft_if #(.DSIZE(DW)) bus ();

  rdata_fwft #(
    .DSIZE    (DW),
    .ADDRSIZE (4)
  ) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] src_q[$];   // words sitting in the FIFO
  logic [DW-1:0] buf_q[$];   // words held by the adapter, head first
  logic          inflight_m; // a read was issued last cycle
  logic          force_empty;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One or more clock cycles: present rempty, check outputs mid-cycle,
  // advance the model at the edge, then drive rdata for the next cycle.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      logic pop_m;
      logic rinc_m;
      logic valid_m;
      int   lvl;
      bus.rempty = force_empty || (src_q.size() == 0);
      @(negedge rclk);
      valid_m = !rrst && (buf_q.size() != 0);
      pop_m   = valid_m && bus.dout_ready;
      lvl     = buf_q.size() + int'(inflight_m) - int'(pop_m);
      rinc_m  = !rrst && !bus.rempty && (lvl < 2);
      check("rinc", 32'(bus.rinc), 32'(rinc_m));
      check("dout_valid", 32'(bus.dout_valid), 32'(valid_m));
      check("dout_count", 32'(bus.dout_count), rrst ? 32'd0 : 32'(buf_q.size()));
      if (valid_m) check("dout_data", 32'(bus.dout_data), 32'(buf_q[0]));
      @(posedge rclk);
      if (rrst) begin
        buf_q.delete();
        src_q.delete();
        inflight_m = 1'b0;
      end else begin
        if (pop_m) void'(buf_q.pop_front());
        if (inflight_m) buf_q.push_back(bus.rdata);
        inflight_m = rinc_m;
      end
      #1;
      if (inflight_m) bus.rdata = src_q.pop_front();
      else bus.rdata = DW'($urandom);
    end
  endtask

  initial begin
    rrst           = 1'b1;
    bus.dout_ready = 1'b0;
    bus.rdata      = '0;
    bus.rempty     = 1'b1;
    force_empty    = 1'b0;
    inflight_m     = 1'b0;

    // Reset held two cycles with a non-empty FIFO: no reads, no output.
    for (int i = 0; i < 5; i++) src_q.push_back(DW'(8'h30 + i));
    step(2);
    rrst = 1'b0;
    // The FIFO was reset too; refill and watch the first rinc.
    for (int i = 0; i < 3; i++) src_q.push_back(DW'(8'h40 + i));
    step(1);
    bus.dout_ready = 1'b1;
    step(6);

    // Fall-through of a single word with the consumer stalled.
    bus.dout_ready = 1'b0;
    step(2);
    src_q.push_back(8'hA5);
    step(3);
    check("fallthrough_count", 32'(bus.dout_count), 32'd1);
    check("fallthrough_data", 32'(bus.dout_data), 32'hA5);
    bus.dout_ready = 1'b1;
    step(2);

    // Backpressure with five words queued, then release.
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) src_q.push_back(DW'(8'h50 + i));
    step(6);
    check("bp_count", 32'(bus.dout_count), 32'd2);
    check("bp_head", 32'(bus.dout_data), 32'h50);
    check("bp_fifo_left", 32'(src_q.size()), 32'd3);
    bus.dout_ready = 1'b1;
    step(10);

    // Streaming sixteen words at full rate.
    for (int i = 0; i < 16; i++) src_q.push_back(DW'(i));
    step(20);

    // Empty flag rises right after a read is issued.
    bus.dout_ready = 1'b0;
    src_q.push_back(8'h71);
    src_q.push_back(8'h72);
    step(1);
    force_empty = 1'b1;
    step(4);
    check("race_count", 32'(bus.dout_count), 32'd1);
    force_empty    = 1'b0;
    bus.dout_ready = 1'b1;
    step(5);

    // Reset with a buffered word and a read in flight.
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) src_q.push_back(DW'(8'h80 + i));
    step(3);
    rrst = 1'b1;
    step(1);
    rrst        = 1'b0;
    force_empty = 1'b1;
    step(2);
    check("post_reset_count", 32'(bus.dout_count), 32'd0);
    force_empty = 1'b0;

    // Random traffic, stalls, empty glitches and occasional resets.
    for (int c = 0; c < 600; c++) begin
      bus.dout_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) src_q.push_back(DW'($urandom));
      force_empty = ($urandom_range(0, 7) == 0);
      rrst        = ($urandom_range(0, 99) == 0);
      step(1);
    end
    rrst        = 1'b0;
    force_empty = 1'b0;
    bus.dout_ready = 1'b1;
    step(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
